fade_sequencer: RTL and testbench
=================================

Name: fade_sequencer

Overview:
Generates the `fade_level`/`direction` pair consumed by the sky and sprite renderers (sunrise, sky gradient), and is the writer end of that interface. It runs a frame-locked day/night cycle: NIGHT hold, RISE ramp 0→255, DAY hold, SET ramp 255→0, repeat. All state advances only on the start-of-frame pulse, so outputs are constant across every visible frame.

Parameters:
- FRAMES_PER_STEP, 2, frames per ±1 change of fade_level during RISE/SET; legal range 1..255.
- HOLD_FRAMES, 120, frames spent in NIGHT and in DAY; legal range 1..65535.
- CYCW, 4, width of the completed-cycle counter.

Ports:
- clk_pix  input  1  pixel clock; the only clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- frame  input  1  one-cycle pulse at start of frame (vertical blank).
- enable  input  1  1 = sequencer runs; 0 = all state frozen.
- restart  input  1  synchronous one-cycle request to return to NIGHT.
- fade_level  output  8  current fade level, registered.
- direction  output  1  0 = rising/holding, 1 = setting; registered.
- phase  output  2  0 NIGHT, 1 RISE, 2 DAY, 3 SET; registered.
- step  output  1  one-cycle pulse on the edge where fade_level changes.
- cycles  output  CYCW  count of completed day/night cycles; wraps.

Behaviour:
- Reset (rst_n=0, asynchronous): fade_level=0, direction=0, phase=NIGHT, step=0, cycles=0. The prescaler and hold counter clear. Release is synchronous to clk_pix. Reset mid-ramp discards all progress.
- A frame event is a clock edge with frame=1, enable=1 and restart=0. Nothing changes on other edges except restart. Every output updates on the edge that samples the frame event, so it is visible the next cycle. Latency is 1 clock.
- `step` is 1 for exactly one cycle, following the edge on which fade_level changed. It is 0 otherwise, including on phase changes without a fade change.
- NIGHT:
  - The hold counter increments on each frame event.
  - On the HOLD_FRAMES-th event: phase←RISE, counters clear.
  - fade_level stays 0 and direction stays 0.
- RISE:
  - The prescaler increments on each frame event.
  - On the FRAMES_PER_STEP-th event: prescaler←0, fade_level←fade_level+1, step pulses.
  - If that increment produces 255, phase←DAY on the same edge.
  - RISE therefore lasts exactly 255×FRAMES_PER_STEP frames.
- DAY:
  - Identical hold behaviour to NIGHT, with fade_level held at 255 and direction 0.
  - On the HOLD_FRAMES-th event: phase←SET and direction←1 on the same edge.
- SET:
  - Same prescaler behaviour as RISE, but fade_level decrements.
  - If the decrement produces 0: phase←NIGHT, direction←0, cycles←cycles+1 (modulo 2^CYCW) on the same edge.
- fade_level never wraps. It is saturated by the phase transitions, never 0→255 or 255→0 in one step.
- enable=0: frame pulses are ignored and every register holds. When re-enabled, the partially counted prescaler/hold count resumes where it stopped.
- restart=1 on any edge, regardless of enable or frame: phase←NIGHT, fade_level←0, direction←0, counters clear, step←0. cycles is preserved. Restart has priority over a simultaneous frame pulse.
- Counter widths: prescaler is 8-bit, hold counter is 16-bit. Compare against parameter−1 to avoid overflow.
- Parameter values outside the legal ranges are unsupported. The implementation flags them with a simulation-time fatal check.

Test Plan:
1. Reset: assert rst_n=0 asynchronously mid-RISE with fade_level=100 → fade_level=0, direction=0, phase=0, step=0, cycles=0 immediately, without waiting for a clock edge.
2. NIGHT→RISE timing (FRAMES_PER_STEP=2, HOLD_FRAMES=3): 3 frame pulses → phase=1 after the 3rd. The next 2 pulses → fade_level=1 and a single-cycle step. 510 pulses after entering RISE → fade_level=255, phase=2, exactly 255 step pulses seen.
3. DAY→SET→NIGHT: from DAY, 3 pulses → phase=3 and direction=1 on the same edge. 510 pulses → fade_level=0, phase=0, direction=0, cycles incremented by 1. No underflow to 255.
4. Freeze: enable=0 for 50 frame pulses mid-RISE at fade_level=40 with prescaler=1 → no change. Re-enable; the 1st pulse → fade_level=41.
5. Restart priority: in SET at fade_level=200, drive restart=1 and frame=1 on the same edge → phase=0, fade_level=0, step=0, cycles unchanged.
6. Cycle wrap (CYCW=4, FRAMES_PER_STEP=1, HOLD_FRAMES=1): run 16 full cycles → cycles goes 15→0. Per cycle, fade_level is monotonic within RISE and SET, and frame spacing matches the 1+255+1+255 = 512-frame period.

Source files
------------

// File: rtl/fade_if.sv
// Fade interface between the fade sequencer (writer) and the sky/sprite
// renderers (readers). Every signal is registered by the writer and changes
// only on the clock edge that samples a start-of-frame event.
interface fade_if #(
  parameter int CYCW = 4
);
  logic [7:0]      fade_level;
  logic            direction;
  logic [1:0]      phase;
  logic            step;
  logic [CYCW-1:0] cycles;

  modport master (output fade_level, direction, phase, step, cycles);
  modport slave  (input  fade_level, direction, phase, step, cycles);
endinterface

// File: rtl/fade_sequencer.sv
// Frame-locked day/night sequencer: NIGHT hold, RISE ramp 0->255, DAY hold,
// SET ramp 255->0, repeat. All state advances only on start-of-frame events,
// so the outputs stay constant across each visible frame.
module fade_sequencer #(
  parameter int FRAMES_PER_STEP = 2,
  parameter int HOLD_FRAMES     = 120,
  parameter int CYCW            = 4
) (
  input  logic   clk_pix,
  input  logic   rst_n,
  input  logic   frame,
  input  logic   enable,
  input  logic   restart,
  fade_if.master bus
);

  typedef enum logic [1:0] {
    NIGHT = 2'd0,
    RISE  = 2'd1,
    DAY   = 2'd2,
    SET   = 2'd3
  } phase_e;

  // Comparing against parameter-1 keeps the counters at their natural width.
  localparam logic [7:0]  STEP_LAST = 8'(FRAMES_PER_STEP - 1);
  localparam logic [15:0] HOLD_LAST = 16'(HOLD_FRAMES - 1);

  if (FRAMES_PER_STEP < 1 || FRAMES_PER_STEP > 255 ||
      HOLD_FRAMES < 1 || HOLD_FRAMES > 65535 || CYCW < 1) begin : g_bad_params
    $fatal(1, "fade_sequencer: FRAMES_PER_STEP, HOLD_FRAMES or CYCW out of legal range");
  end

  phase_e          phase_q, phase_d;
  logic [7:0]      level_q, level_d;
  logic            dir_q, dir_d;
  logic            step_q, step_d;
  logic [CYCW-1:0] cycles_q, cycles_d;
  logic [7:0]      presc_q, presc_d;
  logic [15:0]     hold_q, hold_d;

  logic frame_ev;
  logic hold_done;
  logic step_due;

  // A frame only counts when running and not overridden by restart.
  assign frame_ev  = frame & enable & ~restart;
  assign hold_done = (hold_q == HOLD_LAST);
  assign step_due  = (presc_q == STEP_LAST);

  // State register: every flop, cleared asynchronously on reset.
  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // the same pre-edge values regardless of statement order.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= NIGHT;
      level_q  <= 8'd0;
      dir_q    <= 1'b0;
      step_q   <= 1'b0;
      cycles_q <= '0;
      presc_q  <= 8'd0;
      hold_q   <= 16'd0;
    end else begin
      phase_q  <= phase_d;
      level_q  <= level_d;
      dir_q    <= dir_d;
      step_q   <= step_d;
      cycles_q <= cycles_d;
      presc_q  <= presc_d;
      hold_q   <= hold_d;
    end
  end

  // Next-state logic: phase transitions plus prescaler and hold counters.
  // NOTE: every combinational output is given a default first so no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    phase_d = phase_q;
    presc_d = presc_q;
    hold_d  = hold_q;
    if (restart) begin
      phase_d = NIGHT;
      presc_d = 8'd0;
      hold_d  = 16'd0;
    end else if (frame_ev) begin
      unique case (phase_q)
        NIGHT, DAY: begin
          if (hold_done) begin
            hold_d  = 16'd0;
            presc_d = 8'd0;
            phase_d = (phase_q == NIGHT) ? RISE : SET;
          end else begin
            hold_d = hold_q + 16'd1;
          end
        end
        RISE: begin
          if (step_due) begin
            presc_d = 8'd0;
            if (level_q == 8'd254) phase_d = DAY;
          end else begin
            presc_d = presc_q + 8'd1;
          end
        end
        SET: begin
          if (step_due) begin
            presc_d = 8'd0;
            if (level_q == 8'd1) phase_d = NIGHT;
          end else begin
            presc_d = presc_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output logic: fade level, direction, step pulse and cycle count.
  always_comb begin
    level_d  = level_q;
    dir_d    = dir_q;
    step_d   = 1'b0;
    cycles_d = cycles_q;
    if (restart) begin
      level_d = 8'd0;
      dir_d   = 1'b0;
    end else if (frame_ev) begin
      unique case (phase_q)
        RISE: begin
          if (step_due) begin
            level_d = level_q + 8'd1;
            step_d  = 1'b1;
          end
        end
        DAY: begin
          if (hold_done) dir_d = 1'b1;
        end
        SET: begin
          if (step_due) begin
            level_d = level_q - 8'd1;
            step_d  = 1'b1;
            if (level_q == 8'd1) begin
              dir_d    = 1'b0;
              cycles_d = cycles_q + CYCW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.fade_level = level_q;
  assign bus.direction  = dir_q;
  assign bus.phase      = phase_q;
  assign bus.step       = step_q;
  assign bus.cycles     = cycles_q;

endmodule

// File: tb/tb_fade_sequencer.sv
// Scoreboard bench for fade_sequencer. Two instances share the stimulus:
// A (FRAMES_PER_STEP=2, HOLD_FRAMES=3) and B (FRAMES_PER_STEP=1,
// HOLD_FRAMES=1). The reference model derives the expected outputs from the
// number of frame events since the last restart/reset, using the period of
// the day/night cycle directly.
module tb_fade_sequencer;

  typedef struct packed {
    logic [7:0] level;
    logic       dir;
    logic [1:0] phase;
    logic       step;
    logic [3:0] cycles;
  } exp_t;

  typedef struct packed {
    exp_t a;
    exp_t b;
  } sb_t;

  logic clk_pix = 1'b0;
  logic rst_n   = 1'b0;
  logic frame   = 1'b0;
  logic enable  = 1'b0;
  logic restart = 1'b0;

  always #5 clk_pix = ~clk_pix;

  fade_if #(.CYCW(4)) bus_a ();
  fade_if #(.CYCW(4)) bus_b ();

  fade_sequencer #(.FRAMES_PER_STEP(2), .HOLD_FRAMES(3), .CYCW(4)) dut_a (
    .clk_pix (clk_pix),
    .rst_n   (rst_n),
    .frame   (frame),
    .enable  (enable),
    .restart (restart),
    .bus     (bus_a)
  );

  fade_sequencer #(.FRAMES_PER_STEP(1), .HOLD_FRAMES(1), .CYCW(4)) dut_b (
    .clk_pix (clk_pix),
    .rst_n   (rst_n),
    .frame   (frame),
    .enable  (enable),
    .restart (restart),
    .bus     (bus_b)
  );

  int n_vec = 0;
  int n_bad = 0;
  sb_t sb_q[$];

  // Reference model state, index 0 = instance A, 1 = instance B.
  int unsigned t_m[2];
  int unsigned base_m[2];
  exp_t        cur_m[2];

  function automatic int unsigned fps_of(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  function automatic int unsigned hold_of(input int k);
    return (k == 0) ? 3 : 1;
  endfunction

  // Outputs after t frame events since the last restart, given the cycle
  // count held at that restart.
  function automatic exp_t model(input int unsigned t, input int unsigned base,
                                 input int unsigned f, input int unsigned h);
    int unsigned p, r;
    exp_t e;
    p = 2 * h + 510 * f;
    r = t % p;
    e.step   = 1'b0;
    e.cycles = 4'((base + t / p) % 16);
    if (r < h) begin
      e.phase = 2'd0; e.level = 8'd0; e.dir = 1'b0;
    end else if (r < h + 255 * f) begin
      e.phase = 2'd1; e.level = 8'((r - h) / f); e.dir = 1'b0;
    end else if (r < 2 * h + 255 * f) begin
      e.phase = 2'd2; e.level = 8'd255; e.dir = 1'b0;
    end else begin
      e.phase = 2'd3; e.level = 8'(255 - (r - 2 * h - 255 * f) / f); e.dir = 1'b1;
    end
    return e;
  endfunction

  function automatic exp_t sample(input int k);
    exp_t g;
    if (k == 0) g = '{level: bus_a.fade_level, dir: bus_a.direction, phase: bus_a.phase,
                      step: bus_a.step, cycles: bus_a.cycles};
    else        g = '{level: bus_b.fade_level, dir: bus_b.direction, phase: bus_b.phase,
                      step: bus_b.step, cycles: bus_b.cycles};
    return g;
  endfunction

  task automatic check(input string name, input exp_t got, input exp_t exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got lvl=%0d dir=%0d ph=%0d step=%0d cyc=%0d, expected lvl=%0d dir=%0d ph=%0d step=%0d cyc=%0d",
               name, $time, got.level, got.dir, got.phase, got.step, got.cycles,
               exp.level, exp.dir, exp.phase, exp.step, exp.cycles);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: bound expired before target state was reached", name);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      t_m[k]    = 0;
      base_m[k] = 0;
      cur_m[k]  = model(0, 0, fps_of(k), hold_of(k));
    end
  endtask

  // Drive one clock's inputs and queue the outputs expected after that edge.
  task automatic drive(input logic f, input logic en, input logic rs);
    sb_t e;
    exp_t nx;
    @(negedge clk_pix);
    frame   = f;
    enable  = en;
    restart = rs;
    for (int k = 0; k < 2; k++) begin
      if (rs) begin
        base_m[k] = cur_m[k].cycles;
        t_m[k]    = 0;
        nx = model(0, base_m[k], fps_of(k), hold_of(k));
      end else if (f && en) begin
        t_m[k]++;
        nx = model(t_m[k], base_m[k], fps_of(k), hold_of(k));
        nx.step = (nx.level != cur_m[k].level);
      end else begin
        nx = cur_m[k];
        nx.step = 1'b0;
      end
      cur_m[k] = nx;
    end
    e.a = cur_m[0];
    e.b = cur_m[1];
    sb_q.push_back(e);
  endtask

  task automatic rnd_cycle();
    drive(1'($urandom_range(0, 1)), ($urandom_range(0, 9) != 0), 1'b0);
  endtask

  // Monitor: after each active edge, compare the DUTs with the oldest entry.
  initial begin : monitor
    sb_t e;
    forever begin
      @(posedge clk_pix);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("dut_a", sample(0), e.a);
        check("dut_b", sample(1), e.b);
      end
    end
  end

  initial begin : stim
    exp_t zero;
    int n;
    int wraps;
    logic [3:0] prev_cyc;
    zero = '0;

    // Power-on reset.
    repeat (3) @(negedge clk_pix);
    check("por_a", sample(0), zero);
    check("por_b", sample(1), zero);
    rst_n = 1'b1;
    model_reset();

    // Random run into RISE with A at level 100, then asynchronous reset.
    n = 0;
    while (!(cur_m[0].phase == 2'd1 && cur_m[0].level == 8'd100)) begin
      rnd_cycle();
      if (++n > 5000) begin timeout("reach_rise_100"); break; end
    end
    drive(1'b0, 1'b1, 1'b0);
    @(posedge clk_pix);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_a", sample(0), zero);
    check("async_rst_b", sample(1), zero);
    @(negedge clk_pix);
    @(negedge clk_pix);
    rst_n = 1'b1;
    model_reset();

    // Freeze in RISE at A level 40 with one frame already prescaled.
    n = 0;
    while (!(cur_m[0].phase == 2'd1 && cur_m[0].level == 8'd40 &&
             ((t_m[0] % 1026) - 3) % 2 == 1)) begin
      rnd_cycle();
      if (++n > 5000) begin timeout("reach_rise_40"); break; end
    end
    repeat (50) begin
      drive(1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
    end
    drive(1'b1, 1'b1, 1'b0);

    // Complete one full cycle on A (covers 254->255 and 1->0 boundaries).
    n = 0;
    while (cur_m[0].cycles != 4'd1) begin
      rnd_cycle();
      if (++n > 10000) begin timeout("reach_cycle_1"); break; end
    end

    // Restart with a simultaneous frame while A is setting at level 200.
    n = 0;
    while (!(cur_m[0].phase == 2'd3 && cur_m[0].level == 8'd200)) begin
      rnd_cycle();
      if (++n > 10000) begin timeout("reach_set_200"); break; end
    end
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b0);

    // Continuous frames until B's cycle counter wraps 15->0.
    wraps = 0;
    n = 0;
    prev_cyc = cur_m[1].cycles;
    while (wraps == 0) begin
      drive(1'b1, 1'b1, 1'b0);
      if (prev_cyc == 4'd15 && cur_m[1].cycles == 4'd0) wraps++;
      prev_cyc = cur_m[1].cycles;
      if (++n > 20000) begin timeout("cycle_wrap"); break; end
    end
    repeat (600) drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);

    // Let the monitor drain the scoreboard.
    n = 0;
    while (sb_q.size() > 0) begin
      @(negedge clk_pix);
      if (++n > 20) begin timeout("drain"); break; end
    end
    @(negedge clk_pix);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
